// File: rtl/i2s_encoder_pkg.sv
// Shared constants and helpers for the I2S transmitter.
// Word-select encoding matches the companion i2s_decoder.
package i2s_encoder_pkg;

    localparam logic WS_LEFT          = 1'b0;
    localparam logic WS_RIGHT         = 1'b1;
    localparam int   DEFAULT_SAMPLE_W = 16;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    // WS leads the slot MSB by one SCK (I2S one-bit delay).
    function automatic logic ws_for_bit(input int unsigned b, input int unsigned slot_w);
        if ((b >= slot_w - 1) && (b <= 2 * slot_w - 2)) begin
            return WS_RIGHT;
        end
        return WS_LEFT;
    endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// SCK divider: toggles sck every CLK_DIV clk cycles.
// fall_tick_o is high in the clk whose edge drives sck 1->0.
module i2s_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic sck_o,
    output logic fall_tick_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             sck_q, sck_d;
    logic             term;

    assign term = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d = div_q + 1'b1;
        sck_d = sck_q;
        if (term) begin
            div_d = '0;
            sck_d = ~sck_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            sck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o       = sck_q;
    assign fall_tick_o = term & sck_q;

endmodule

// File: rtl/i2s_encoder.sv
// I2S master transmitter: one-entry sample buffer, frame loaded on the b==0 SCK fall.
// Optional I2S_UNDERRUN_MUTE_EN: send silence instead of repeating the last pair on underrun.
module i2s_encoder
    import i2s_encoder_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int SAMPLE_W = DEFAULT_SAMPLE_W,
    parameter int SLOT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] left_in,
    input  logic [SAMPLE_W-1:0] right_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                sck,
    output logic                ws,
    output logic                sd,
    output logic                frame_start,
    output logic                underrun
);

    localparam int B_W = $clog2(2 * SLOT_W);

    logic                fall_tick;
    logic                sck_int;

    logic [B_W-1:0]      b_q, b_d;
    logic                full_q, full_d;
    logic [SAMPLE_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [SAMPLE_W-1:0] shl_q, shl_d, shr_q, shr_d;
    logic                ws_q, ws_d, sd_q, sd_d;
    logic                fs_q, fs_d, ur_q, ur_d;

    logic                frame_load;
    logic                accept;
    chan_e               chan;
    logic [B_W-1:0]      k;
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] shifted;

    i2s_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk         (clk),
        .rst         (rst),
        .sck_o       (sck_int),
        .fall_tick_o (fall_tick)
    );

    assign frame_load = fall_tick && (b_q == '0);
    assign accept     = in_valid && !full_q;

    always_comb begin
        shl_d   = shl_q;
        shr_d   = shr_q;
        buf_l_d = buf_l_q;
        buf_r_d = buf_r_q;
        full_d  = full_q;

        if (frame_load) begin
            if (full_q) begin
                shl_d  = buf_l_q;
                shr_d  = buf_r_q;
                full_d = 1'b0;
            end else begin
`ifdef I2S_UNDERRUN_MUTE_EN
                shl_d = '0;
                shr_d = '0;
`else
                shl_d = shl_q;
                shr_d = shr_q;
`endif
            end
        end

        // No bypass: a pair accepted in the load clk waits for the next frame.
        if (accept) begin
            full_d  = 1'b1;
            buf_l_d = left_in;
            buf_r_d = right_in;
        end
    end

    always_comb begin
        chan    = (b_q < B_W'(SLOT_W)) ? CH_LEFT : CH_RIGHT;
        k       = (chan == CH_LEFT) ? b_q : (b_q - B_W'(SLOT_W));
        sample  = (chan == CH_LEFT) ? shl_d : shr_d;
        // Shifting past the sample width leaves zeros: that is the slot padding.
        shifted = sample << k;

        b_d  = b_q;
        ws_d = ws_q;
        sd_d = sd_q;
        if (fall_tick) begin
            b_d  = (b_q == B_W'(2 * SLOT_W - 1)) ? '0 : (b_q + 1'b1);
            ws_d = ws_for_bit(32'(b_q), SLOT_W);
            sd_d = shifted[SAMPLE_W-1];
        end

        fs_d = frame_load;
        ur_d = frame_load && !full_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q     <= '0;
            full_q  <= 1'b0;
            buf_l_q <= '0;
            buf_r_q <= '0;
            shl_q   <= '0;
            shr_q   <= '0;
            ws_q    <= WS_LEFT;
            sd_q    <= 1'b0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            b_q     <= b_d;
            full_q  <= full_d;
            buf_l_q <= buf_l_d;
            buf_r_q <= buf_r_d;
            shl_q   <= shl_d;
            shr_q   <= shr_d;
            ws_q    <= ws_d;
            sd_q    <= sd_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
        end
    end

    assign in_ready    = !full_q;
    assign sck         = sck_int;
    assign ws          = ws_q;
    assign sd          = sd_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;

endmodule

// File: tb/tb_i2s_encoder.sv
// Directed bench for i2s_encoder (CLK_DIV=4): main instance SLOT_W=16, second instance SLOT_W=32.
module tb_i2s_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] left_in  = '0;
    logic [15:0] right_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, sck, ws, sd, frame_start, underrun;

    logic [15:0] l32 = '0;
    logic [15:0] r32 = '0;
    logic        v32 = 1'b0;
    logic        in_ready32, sck32, ws32, sd32, fs32, ur32;

    int   checks   = 0;
    int   fails    = 0;
    int   fc       = -1;
    logic prev_sck = 1'b0;
    int   acc_cnt  = 0;
    int   ur_cnt   = 0;

    always #5 clk = ~clk;

    i2s_encoder #(.CLK_DIV(4), .SAMPLE_W(16), .SLOT_W(16)) dut (
        .clk(clk), .rst(rst), .left_in(left_in), .right_in(right_in),
        .in_valid(in_valid), .in_ready(in_ready), .sck(sck), .ws(ws), .sd(sd),
        .frame_start(frame_start), .underrun(underrun)
    );

    i2s_encoder #(.CLK_DIV(4), .SAMPLE_W(16), .SLOT_W(32)) dut32 (
        .clk(clk), .rst(rst), .left_in(l32), .right_in(r32),
        .in_valid(v32), .in_ready(in_ready32), .sck(sck32), .ws(ws32), .sd(sd32),
        .frame_start(fs32), .underrun(ur32)
    );

    always @(posedge clk) if (!rst && in_valid && in_ready) acc_cnt++;
    always @(negedge clk) if (underrun) ur_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to the next SCK fall, sampled on the clk falling edge.
    task automatic next_fall(output int n_cyc);
        bit got = 1'b0;
        n_cyc = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            n_cyc++;
            if (prev_sck && !sck) got = 1'b1;
            prev_sck = sck;
        end
        if (!got) begin
            checks++; fails++;
            $display("FAIL fall_timeout: no SCK fall within 40 clk");
        end
        fc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (sck !== 1'b0)         begin fails++; $display("FAIL reset_sck: got %b want 0", sck); end
        checks++; if (ws !== 1'b0)          begin fails++; $display("FAIL reset_ws: got %b want 0", ws); end
        checks++; if (sd !== 1'b0)          begin fails++; $display("FAIL reset_sd: got %b want 0", sd); end
        checks++; if (in_ready !== 1'b1)    begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
        checks++; if (underrun !== 1'b0)    begin fails++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_sck_timing();
        int n, m, cyc;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && sck !== 1'b1; i++) begin @(negedge clk); n++; end
        checks++; if (n != 4) begin fails++; $display("FAIL first_rise: got %0d clk want 4", n); end
        m = 0;
        for (int i = 0; i < 20 && sck !== 1'b0; i++) begin @(negedge clk); m++; end
        checks++; if (m != 4) begin fails++; $display("FAIL first_fall: got %0d clk after rise want 4", m); end
        prev_sck = 1'b0;
        fc = 0;
        checks++; if (frame_start !== 1'b1) begin fails++; $display("FAIL first_frame_start: got %b want 1", frame_start); end
        checks++; if (underrun !== 1'b1)    begin fails++; $display("FAIL first_underrun: got %b want 1", underrun); end
        checks++; if (ws !== 1'b0)          begin fails++; $display("FAIL first_ws: got %b want 0", ws); end
        for (int b = 1; b < 32; b++) begin
            next_fall(cyc);
            checks++; if (cyc != 8) begin fails++; $display("FAIL sck_period b=%0d: got %0d clk want 8", b, cyc); end
            checks++;
            if (ws !== ((b >= 15 && b <= 30) ? 1'b1 : 1'b0)) begin
                fails++; $display("FAIL ws_pattern b=%0d: got %b want %b", b, ws, (b >= 15 && b <= 30));
            end
        end
    endtask

    task automatic test_data();
        logic [31:0] exp;
        int cyc;
        exp = {16'hA5F0, 16'h0F5A};
        in_valid = 1'b1; left_in = 16'hA5F0; right_in = 16'h0F5A;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL data_accept: in_ready got %b want 0", in_ready); end
        for (int b = 0; b < 32; b++) begin
            next_fall(cyc);
            if (b == 0) begin
                checks++; if (frame_start !== 1'b1) begin fails++; $display("FAIL data_frame_start: got %b want 1", frame_start); end
                checks++; if (underrun !== 1'b0)    begin fails++; $display("FAIL data_underrun: got %b want 0", underrun); end
            end
            checks++; if (sd !== exp[31-b]) begin fails++; $display("FAIL data_sd b=%0d: got %b want %b", b, sd, exp[31-b]); end
        end
    endtask

    task automatic test_underrun();
        logic [31:0] exp;
        int cyc, ur0;
`ifdef I2S_UNDERRUN_MUTE_EN
        exp = 32'h0;
`else
        exp = {16'hA5F0, 16'h0F5A};
`endif
        ur0 = ur_cnt;
        for (int b = 0; b < 32; b++) begin
            next_fall(cyc);
            if (b == 0) begin
                checks++; if (underrun !== 1'b1)    begin fails++; $display("FAIL ur_pulse: got %b want 1", underrun); end
                checks++; if (frame_start !== 1'b1) begin fails++; $display("FAIL ur_frame_start: got %b want 1", frame_start); end
            end
            checks++; if (sd !== exp[31-b]) begin fails++; $display("FAIL ur_sd b=%0d: got %b want %b", b, sd, exp[31-b]); end
        end
        checks++; if (ur_cnt - ur0 != 1) begin fails++; $display("FAIL ur_count: got %0d pulses want 1", ur_cnt - ur0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        int cyc, acc0;
        exp = {16'h1234, 16'h5678};
        acc0 = acc_cnt;
        in_valid = 1'b1; left_in = 16'h1234; right_in = 16'h5678;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_first_accept: in_ready got %b want 0", in_ready); end
        left_in = 16'hFFFF; right_in = 16'hFFFF;
        for (int b = 0; b < 32; b++) begin
            next_fall(cyc);
            if (b == 0) begin
                checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_after_load: got %b want 1", in_ready); end
                @(negedge clk);
                checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_after_accept: got %b want 0", in_ready); end
                prev_sck = sck;
            end
            checks++; if (sd !== exp[31-b]) begin fails++; $display("FAIL b2b_sd b=%0d: got %b want %b", b, sd, exp[31-b]); end
        end
        checks++; if (acc_cnt - acc0 != 2) begin fails++; $display("FAIL b2b_accepts: got %0d want 2", acc_cnt - acc0); end
        next_fall(cyc);
        in_valid = 1'b0;
        checks++; if (sd !== 1'b1) begin fails++; $display("FAIL b2b_next_pair_msb: got %b want 1", sd); end
        checks++; if (underrun !== 1'b0) begin fails++; $display("FAIL b2b_no_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        @(negedge clk);
        in_valid = 1'b1; left_in = 16'h1111; right_in = 16'h2222;
        @(negedge clk);
        in_valid = 1'b0;
        prev_sck = sck;
        for (int b = 1; b <= 20; b++) next_fall(cyc);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (sck !== 1'b0)         begin fails++; $display("FAIL mid_rst_sck: got %b want 0", sck); end
        checks++; if (ws !== 1'b0)          begin fails++; $display("FAIL mid_rst_ws: got %b want 0", ws); end
        checks++; if (sd !== 1'b0)          begin fails++; $display("FAIL mid_rst_sd: got %b want 0", sd); end
        checks++; if (in_ready !== 1'b1)    begin fails++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); end
        checks++; if (frame_start !== 1'b0) begin fails++; $display("FAIL mid_rst_frame_start: got %b want 0", frame_start); end
        @(negedge clk);
        rst = 1'b0;
        prev_sck = 1'b0;
        fc = -1;
        next_fall(cyc);
        checks++; if (cyc != 8)             begin fails++; $display("FAIL restart_fall: got %0d clk want 8", cyc); end
        checks++; if (frame_start !== 1'b1) begin fails++; $display("FAIL restart_frame_start: got %b want 1", frame_start); end
        checks++; if (underrun !== 1'b1)    begin fails++; $display("FAIL restart_underrun: got %b want 1", underrun); end
        checks++; if (ws !== 1'b0)          begin fails++; $display("FAIL restart_ws: got %b want 0", ws); end
        checks++; if (sd !== 1'b0)          begin fails++; $display("FAIL restart_sd: got %b want 0", sd); end
    endtask

    task automatic test_slot32();
        logic [15:0] lv, rv, v;
        logic        exp_sd, exp_ws;
        int          cyc, k;
        lv = 16'hA5F0; rv = 16'h0F5A;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prev_sck = 1'b0;
        fc = -1;
        v32 = 1'b1; l32 = lv; r32 = rv;
        @(negedge clk);
        v32 = 1'b0;
        checks++; if (in_ready32 !== 1'b0) begin fails++; $display("FAIL s32_accept: in_ready got %b want 0", in_ready32); end
        for (int b = 0; b < 64; b++) begin
            next_fall(cyc);
            v      = (b < 32) ? lv : rv;
            k      = b % 32;
            exp_sd = (k < 16) ? v[15-k] : 1'b0;
            exp_ws = (b >= 31 && b <= 62) ? 1'b1 : 1'b0;
            if (b == 0) begin
                checks++; if (fs32 !== 1'b1) begin fails++; $display("FAIL s32_frame_start: got %b want 1", fs32); end
                checks++; if (ur32 !== 1'b0) begin fails++; $display("FAIL s32_underrun: got %b want 0", ur32); end
            end
            checks++; if (sd32 !== exp_sd) begin fails++; $display("FAIL s32_sd b=%0d: got %b want %b", b, sd32, exp_sd); end
            checks++; if (ws32 !== exp_ws) begin fails++; $display("FAIL s32_ws b=%0d: got %b want %b", b, ws32, exp_ws); end
        end
    endtask

    initial begin
        test_reset();
        test_sck_timing();
        test_data();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        test_slot32();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
